// File: rtl/vga_timing_pkg.sv
//----------------------------------------------------------------------------
// vga_timing_pkg : 640x480@60 VGA timing constants and phase enums  (rev 1.0)
//----------------------------------------------------------------------------
`default_nettype none

package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int H_ACTIVE_LEN = 640;
  localparam int H_FRONT_LEN  = 16;
  localparam int H_SYNC_LEN   = 96;
  localparam int H_BACK_LEN   = 48;
  localparam int H_TOTAL      = H_ACTIVE_LEN + H_FRONT_LEN + H_SYNC_LEN + H_BACK_LEN;

  localparam int V_ACTIVE_LEN = 480;
  localparam int V_FRONT_LEN  = 10;
  localparam int V_SYNC_LEN   = 2;
  localparam int V_BACK_LEN   = 33;
  localparam int V_TOTAL      = V_ACTIVE_LEN + V_FRONT_LEN + V_SYNC_LEN + V_BACK_LEN;

  // Shared encoding: the generic phase counter reports phase_t, which the
  // top reinterprets as the axis-specific state type.
  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_t;

  typedef enum logic [1:0] {
    H_ACTIVE = 2'd0,
    H_FRONT  = 2'd1,
    H_SYNC   = 2'd2,
    H_BACK   = 2'd3
  } h_state_t;

  typedef enum logic [1:0] {
    V_ACTIVE = 2'd0,
    V_FRONT  = 2'd1,
    V_SYNC   = 2'd2,
    V_BACK   = 2'd3
  } v_state_t;

endpackage

`default_nettype wire

// File: rtl/vga_phase_counter.sv
//----------------------------------------------------------------------------
// vga_phase_counter : position counter with 4-phase FSM and advance enable  (rev 1.0)
//----------------------------------------------------------------------------
`default_nettype none

module vga_phase_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE_LEN,
  parameter int FRONT  = H_FRONT_LEN,
  parameter int SYNC   = H_SYNC_LEN,
  parameter int BACK   = H_BACK_LEN
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  input  logic             advance,
  output logic [CNT_W-1:0] count_nxt,
  output phase_t           phase_nxt,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST     = CNT_W'(ACTIVE + FRONT + SYNC + BACK - 1);
  localparam logic [CNT_W-1:0] FRONT_AT = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_AT  = CNT_W'(ACTIVE + FRONT);
  localparam logic [CNT_W-1:0] BACK_AT  = CNT_W'(ACTIVE + FRONT + SYNC);

  logic [CNT_W-1:0] count_q;
  phase_t           phase_q;

  // Next position is exported so the parent can register its outputs from
  // the same value the counter is about to hold, keeping everything aligned.
  always_comb begin
    count_nxt = count_q;
    phase_nxt = phase_q;
    wrap      = advance && (count_q >= LAST);
    if (advance) begin
      count_nxt = (count_q >= LAST) ? '0 : count_q + CNT_W'(1);
      case (phase_q)
        PH_ACTIVE: if (count_nxt == FRONT_AT) phase_nxt = PH_FRONT;
        PH_FRONT:  if (count_nxt == SYNC_AT)  phase_nxt = PH_SYNC;
        PH_SYNC:   if (count_nxt == BACK_AT)  phase_nxt = PH_BACK;
        PH_BACK:   if (count_nxt == '0)       phase_nxt = PH_ACTIVE;
        default:                              phase_nxt = PH_BACK;
      endcase
      // Any wrap, including recovery from an out-of-range count, restarts the line.
      if (count_nxt == '0) phase_nxt = PH_ACTIVE;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= LAST;
      phase_q <= PH_BACK;
    end else begin
      count_q <= count_nxt;
      phase_q <= phase_nxt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
//----------------------------------------------------------------------------
// vga_timing_gen : registered VGA sync, blank, position and frame counter  (rev 1.0)
//----------------------------------------------------------------------------
`default_nettype none

module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE     = H_ACTIVE_LEN,
  parameter int H_FRONT_PORCH = H_FRONT_LEN,
  parameter int H_SYNC_WIDTH  = H_SYNC_LEN,
  parameter int H_BACK_PORCH  = H_BACK_LEN,
  parameter int V_VISIBLE     = V_ACTIVE_LEN,
  parameter int V_FRONT_PORCH = V_FRONT_LEN,
  parameter int V_SYNC_WIDTH  = V_SYNC_LEN,
  parameter int V_BACK_PORCH  = V_BACK_LEN
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  output logic             hs,
  output logic             vs,
  output logic             blank,
  output logic [CNT_W-1:0] DrawX,
  output logic [CNT_W-1:0] DrawY,
  output logic             line_start,
  output logic             frame_start,
  output logic [7:0]       frame_count
);

  logic [CNT_W-1:0] x_nxt;
  logic [CNT_W-1:0] y_nxt;
  phase_t           h_phase_nxt;
  phase_t           v_phase_nxt;
  h_state_t         h_state_nxt;
  v_state_t         v_state_nxt;
  logic             x_wrap;
  logic             y_wrap;

  vga_phase_counter #(
    .ACTIVE (H_VISIBLE),
    .FRONT  (H_FRONT_PORCH),
    .SYNC   (H_SYNC_WIDTH),
    .BACK   (H_BACK_PORCH)
  ) u_h_counter (
    .vga_clk   (vga_clk),
    .reset_n   (reset_n),
    .advance   (1'b1),
    .count_nxt (x_nxt),
    .phase_nxt (h_phase_nxt),
    .wrap      (x_wrap)
  );

  // The vertical axis only moves on the cycle the line wraps, so its wrap
  // flag doubles as the start-of-frame condition.
  vga_phase_counter #(
    .ACTIVE (V_VISIBLE),
    .FRONT  (V_FRONT_PORCH),
    .SYNC   (V_SYNC_WIDTH),
    .BACK   (V_BACK_PORCH)
  ) u_v_counter (
    .vga_clk   (vga_clk),
    .reset_n   (reset_n),
    .advance   (x_wrap),
    .count_nxt (y_nxt),
    .phase_nxt (v_phase_nxt),
    .wrap      (y_wrap)
  );

  assign h_state_nxt = h_state_t'(h_phase_nxt);
  assign v_state_nxt = v_state_t'(v_phase_nxt);

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs          <= 1'b1;
      vs          <= 1'b1;
      blank       <= 1'b0;
      DrawX       <= '0;
      DrawY       <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      hs          <= (h_state_nxt != H_SYNC);
      vs          <= (v_state_nxt != V_SYNC);
      blank       <= (h_state_nxt == H_ACTIVE) && (v_state_nxt == V_ACTIVE);
      DrawX       <= x_nxt;
      DrawY       <= y_nxt;
      line_start  <= x_wrap;
      frame_start <= y_wrap;
      if (y_wrap) frame_count <= frame_count + 8'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
//----------------------------------------------------------------------------
// tb_vga_timing_gen : directed self-checking bench for vga_timing_gen  (rev 1.0)
//----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_vga_timing_gen;

  logic       vga_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       reset_s_n = 1'b0;

  logic       hs, vs, blank, line_start, frame_start;
  logic [9:0] DrawX, DrawY;
  logic [7:0] frame_count;

  logic       hs_s, vs_s, blank_s, line_start_s, frame_start_s;
  logic [9:0] DrawX_s, DrawY_s;
  logic [7:0] frame_count_s;

  int total = 0;
  int bad   = 0;
  int prev_x = -1;
  int prev_y = -1;

  always #20 vga_clk = ~vga_clk;

  vga_timing_gen dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .hs          (hs),
    .vs          (vs),
    .blank       (blank),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .line_start  (line_start),
    .frame_start (frame_start),
    .frame_count (frame_count)
  );

  // Shrunken timing (8 clocks x 6 lines) so 256 frames fit in a short run.
  vga_timing_gen #(
    .H_VISIBLE(4), .H_FRONT_PORCH(1), .H_SYNC_WIDTH(2), .H_BACK_PORCH(1),
    .V_VISIBLE(3), .V_FRONT_PORCH(1), .V_SYNC_WIDTH(1), .V_BACK_PORCH(1)
  ) dut_small (
    .vga_clk     (vga_clk),
    .reset_n     (reset_s_n),
    .hs          (hs_s),
    .vs          (vs_s),
    .blank       (blank_s),
    .DrawX       (DrawX_s),
    .DrawY       (DrawY_s),
    .line_start  (line_start_s),
    .frame_start (frame_start_s),
    .frame_count (frame_count_s)
  );

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge vga_clk);
    total++;
    if ({hs, vs, blank, line_start, frame_start} !== 5'b11000) begin
      bad++;
      $display("FAIL reset_flags: got hs/vs/blank/ls/fs=%b required 11000",
               {hs, vs, blank, line_start, frame_start});
    end
    total++;
    if (DrawX !== 10'd0 || DrawY !== 10'd0 || frame_count !== 8'd0) begin
      bad++;
      $display("FAIL reset_counts: got X=%0d Y=%0d fc=%0d required 0 0 0", DrawX, DrawY, frame_count);
    end
    reset_n = 1'b1;
    @(negedge vga_clk);
    total++;
    if (DrawX !== 10'd0 || DrawY !== 10'd0 || frame_count !== 8'd1) begin
      bad++;
      $display("FAIL first_cycle_pos: got X=%0d Y=%0d fc=%0d required 0 0 1", DrawX, DrawY, frame_count);
    end
    total++;
    if ({hs, vs, blank, line_start, frame_start} !== 5'b11111) begin
      bad++;
      $display("FAIL first_cycle_flags: got hs/vs/blank/ls/fs=%b required 11111",
               {hs, vs, blank, line_start, frame_start});
    end
  endtask

  task automatic test_line();
    int   blank_cnt = 0;
    int   hs_cnt = 0;
    int   hs_first = -1;
    int   hs_falls = 0;
    int   ls_cnt = 0;
    int   x_bad = 0;
    logic prev_hs = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if (DrawX !== 10'(i) || DrawY !== 10'd0) x_bad++;
      if (blank === 1'b1) blank_cnt++;
      if (hs === 1'b0) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = i;
      end
      if (prev_hs === 1'b1 && hs === 1'b0) hs_falls++;
      prev_hs = hs;
      if (line_start === 1'b1) ls_cnt++;
      @(negedge vga_clk);
    end
    total++;
    if (x_bad != 0) begin bad++; $display("FAIL line_x_sequence: got %0d wrong samples required 0", x_bad); end
    total++;
    if (blank_cnt != 640) begin bad++; $display("FAIL line_blank_count: got %0d required 640", blank_cnt); end
    total++;
    if (hs_cnt != 96 || hs_falls != 1) begin
      bad++; $display("FAIL line_hs_width: got %0d clocks in %0d pulses required 96 in 1", hs_cnt, hs_falls);
    end
    total++;
    if (hs_first != 656) begin bad++; $display("FAIL line_hs_start: got X=%0d required 656", hs_first); end
    total++;
    if (ls_cnt != 1) begin bad++; $display("FAIL line_start_count: got %0d required 1", ls_cnt); end
    total++;
    if (line_start !== 1'b1 || DrawX !== 10'd0 || DrawY !== 10'd1) begin
      bad++;
      $display("FAIL line_period: got ls=%b X=%0d Y=%0d required 1 0 1", line_start, DrawX, DrawY);
    end
  endtask

  task automatic test_frame();
    int   cyc = 800;
    int   guard = 0;
    int   vs_cnt = 0;
    int   vs_fx = -1;
    int   vs_fy = -1;
    int   vs_edge_bad = 0;
    int   blank_cnt = 0;
    int   max_x = 0;
    int   max_y = 0;
    logic prev_vs = 1'b1;
    while (frame_start !== 1'b1 && guard < 430000) begin
      if (blank === 1'b1) blank_cnt++;
      if (vs === 1'b0) begin
        vs_cnt++;
        if (vs_fx < 0) begin vs_fx = int'(DrawX); vs_fy = int'(DrawY); end
      end
      if (vs !== prev_vs && DrawX !== 10'd0) vs_edge_bad++;
      prev_vs = vs;
      if (int'(DrawX) > max_x) max_x = int'(DrawX);
      if (int'(DrawY) > max_y) max_y = int'(DrawY);
      prev_x = int'(DrawX);
      prev_y = int'(DrawY);
      @(negedge vga_clk);
      cyc++;
      guard++;
    end
    total++;
    if (guard >= 430000) begin bad++; $display("FAIL frame_timeout: no frame_start within 430000 clocks"); end
    total++;
    if (cyc != 420000) begin bad++; $display("FAIL frame_period: got %0d required 420000", cyc); end
    total++;
    if (vs_cnt != 1600) begin bad++; $display("FAIL frame_vs_width: got %0d required 1600", vs_cnt); end
    total++;
    if (vs_fx != 0 || vs_fy != 490) begin
      bad++; $display("FAIL frame_vs_start: got X=%0d Y=%0d required 0 490", vs_fx, vs_fy);
    end
    total++;
    if (vs_edge_bad != 0) begin bad++; $display("FAIL frame_vs_align: got %0d edges off X=0 required 0", vs_edge_bad); end
    total++;
    if (blank_cnt != 640 * 479) begin bad++; $display("FAIL frame_blank_count: got %0d required %0d", blank_cnt, 640 * 479); end
    total++;
    if (max_x != 799 || max_y != 524) begin
      bad++; $display("FAIL frame_max_pos: got X=%0d Y=%0d required 799 524", max_x, max_y);
    end
  endtask

  task automatic test_wrap();
    total++;
    if (prev_x != 799 || prev_y != 524) begin
      bad++; $display("FAIL wrap_before: got X=%0d Y=%0d required 799 524", prev_x, prev_y);
    end
    total++;
    if (DrawX !== 10'd0 || DrawY !== 10'd0 || frame_start !== 1'b1 || frame_count !== 8'd2) begin
      bad++;
      $display("FAIL wrap_after: got X=%0d Y=%0d fs=%b fc=%0d required 0 0 1 2",
               DrawX, DrawY, frame_start, frame_count);
    end
  endtask

  task automatic test_reset_mid_frame();
    int guard = 0;
    while (!(DrawX === 10'd300 && DrawY === 10'd200) && guard < 170000) begin
      @(negedge vga_clk);
      guard++;
    end
    total++;
    if (guard >= 170000 || blank !== 1'b1 || hs !== 1'b1) begin
      bad++; $display("FAIL mid_reach: got X=%0d Y=%0d blank=%b required 300 200 1", DrawX, DrawY, blank);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if ({hs, vs, blank, line_start, frame_start} !== 5'b11000 ||
        DrawX !== 10'd0 || DrawY !== 10'd0 || frame_count !== 8'd0) begin
      bad++;
      $display("FAIL mid_reset_async: got flags=%b X=%0d Y=%0d fc=%0d required 11000 0 0 0",
               {hs, vs, blank, line_start, frame_start}, DrawX, DrawY, frame_count);
    end
    @(negedge vga_clk);
    reset_n = 1'b1;
    @(negedge vga_clk);
    total++;
    if ({hs, vs, blank, line_start, frame_start} !== 5'b11111 ||
        DrawX !== 10'd0 || DrawY !== 10'd0 || frame_count !== 8'd1) begin
      bad++;
      $display("FAIL mid_release: got flags=%b X=%0d Y=%0d fc=%0d required 11111 0 0 1",
               {hs, vs, blank, line_start, frame_start}, DrawX, DrawY, frame_count);
    end
  endtask

  task automatic test_frame_count_wrap();
    int pulses = 0;
    int cyc = 0;
    int last = 0;
    int fc_bad = 0;
    int period_bad = 0;
    reset_s_n = 1'b1;
    while (pulses < 256 && cyc < 256 * 48 + 200) begin
      @(negedge vga_clk);
      cyc++;
      if (frame_start_s === 1'b1) begin
        pulses++;
        if (frame_count_s !== 8'(pulses)) fc_bad++;
        if (pulses > 1 && cyc - last != 48) period_bad++;
        last = cyc;
      end
    end
    total++;
    if (pulses != 256) begin bad++; $display("FAIL fc_pulses: got %0d required 256", pulses); end
    total++;
    if (fc_bad != 0) begin bad++; $display("FAIL fc_sequence: got %0d wrong values required 0", fc_bad); end
    total++;
    if (frame_count_s !== 8'd0) begin bad++; $display("FAIL fc_wrap: got %0d required 0", frame_count_s); end
    total++;
    if (period_bad != 0) begin bad++; $display("FAIL fc_period: got %0d bad periods required 0", period_bad); end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_wrap();
    test_reset_mid_frame();
    test_frame_count_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
